// File: rtl/part2.sv
// part2: 2:1 data mux with a registered copy of the result.
//
// Combinational path: M_comb = SE ? YIN : XIN. Nothing on this path is clocked,
// so it also follows the inputs while reset is asserted.
//
// Registered path: a rising clk edge with in_valid=1 is a "capture". A capture
// loads M, eq and last_se, and it may bump sel_changes. When in_valid=0 the
// registered state holds. The one exception is out_valid, which is always a
// one-cycle-delayed copy of in_valid.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   SE           select: 0 -> XIN, 1 -> YIN
//   XIN, YIN     WIDTH-bit data inputs
//   in_valid     qualifies SE/XIN/YIN for capture this cycle
//   M_comb       combinational mux result
//   M            registered mux result (1-cycle latency)
//   out_valid    M holds a result captured on the previous edge
//   eq           XIN == YIN at the last capture
//   sel_changes  saturating count of select toggles between captures
module part2 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SE,
  input  logic [WIDTH-1:0] XIN,
  input  logic [WIDTH-1:0] YIN,
  input  logic             in_valid,
  output logic [WIDTH-1:0] M_comb,
  output logic [WIDTH-1:0] M,
  output logic             out_valid,
  output logic             eq,
  output logic [CNT_W-1:0] sel_changes
);

  logic [WIDTH-1:0] r_m;
  logic             r_eq;
  logic             r_out_valid;
  logic             r_last_se;
  logic             r_primed;
  logic [CNT_W-1:0] r_sel_changes;

  logic [WIDTH-1:0] w_m_comb;
  logic             w_sel_change;
  logic             w_cnt_max;

  assign w_m_comb = SE ? YIN : XIN;

  // A change needs an earlier capture to compare against. Until the first
  // capture after reset (r_primed=0), the reset value of r_last_se means nothing.
  assign w_sel_change = in_valid & r_primed & (SE ^ r_last_se);
  assign w_cnt_max    = &r_sel_changes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m           <= '0;
      r_eq          <= 1'b0;
      r_out_valid   <= 1'b0;
      r_last_se     <= 1'b0;
      r_primed      <= 1'b0;
      r_sel_changes <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_m       <= w_m_comb;
        r_eq      <= (XIN == YIN);
        r_last_se <= SE;
        r_primed  <= 1'b1;
      end
      // Saturate at all-ones rather than wrapping back to zero.
      if (w_sel_change && !w_cnt_max) begin
        r_sel_changes <= r_sel_changes + 1'b1;
      end
    end
  end

  assign M_comb      = w_m_comb;
  assign M           = r_m;
  assign eq          = r_eq;
  assign out_valid   = r_out_valid;
  assign sel_changes = r_sel_changes;

endmodule

// File: tb/tb_part2.sv
// Self-checking bench for part2 (WIDTH=4, CNT_W=8).
// An independent reference model predicts the result of each valid capture.
// The prediction is pushed to a queue when the stimulus is driven, then popped
// and compared after the next rising edge.
module tb_part2;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             SE;
  logic [WIDTH-1:0] XIN;
  logic [WIDTH-1:0] YIN;
  logic             in_valid;
  logic [WIDTH-1:0] M_comb;
  logic [WIDTH-1:0] M;
  logic             out_valid;
  logic             eq;
  logic [CNT_W-1:0] sel_changes;

  part2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .SE         (SE),
    .XIN        (XIN),
    .YIN        (YIN),
    .in_valid   (in_valid),
    .M_comb     (M_comb),
    .M          (M),
    .out_valid  (out_valid),
    .eq         (eq),
    .sel_changes(sel_changes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] m;
    logic             eq;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [WIDTH-1:0] mdl_m;
  logic             mdl_eq;
  logic [CNT_W-1:0] mdl_cnt;
  logic             mdl_last_se;
  logic             mdl_primed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    mdl_m       = '0;
    mdl_eq      = 1'b0;
    mdl_cnt     = '0;
    mdl_last_se = 1'b0;
    mdl_primed  = 1'b0;
  endtask

  // Called shortly after a rising edge. Drives one cycle of stimulus, checks
  // M_comb, then checks the registered outputs after the next rising edge.
  task automatic drive(input logic se, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y, input logic v);
    exp_t e;
    SE = se; XIN = x; YIN = y; in_valid = v;
    #1;
    chk("m_comb", M_comb, se ? y : x);
    if (v) begin
      if (mdl_primed && (se != mdl_last_se) && (mdl_cnt != {CNT_W{1'b1}}))
        mdl_cnt = mdl_cnt + 1'b1;
      mdl_last_se = se;
      mdl_primed  = 1'b1;
      mdl_m       = se ? y : x;
      mdl_eq      = (x == y);
      e.m = mdl_m; e.eq = mdl_eq; e.cnt = mdl_cnt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, v);
    if (v) begin
      if (exp_q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m", M, e.m);
        chk("eq", eq, e.eq);
        chk("sel_changes", sel_changes, e.cnt);
      end
    end else begin
      chk("m_hold", M, mdl_m);
      chk("eq_hold", eq, mdl_eq);
      chk("cnt_hold", sel_changes, mdl_cnt);
    end
  endtask

  // Asserts and releases reset between rising edges. The registered outputs
  // must clear immediately, without waiting for a clock edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_m", M, 0);
    chk("rst_eq", eq, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_cnt", sel_changes, 0);
    chk("rst_m_comb", M_comb, SE ? YIN : XIN);
    #1 reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; SE = 1'b0; XIN = '0; YIN = '0; in_valid = 1'b0;
    model_reset();
    #2;
    chk("init_m", M, 0);
    chk("init_eq", eq, 0);
    chk("init_ov", out_valid, 0);
    chk("init_cnt", sel_changes, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic capture, then a select change on the same data.
    drive(1'b0, 4'b0000, 4'b0001, 1'b1);
    drive(1'b1, 4'b0000, 4'b0001, 1'b1);
    chk("first_change", sel_changes, 1);

    // Idle cycles with changing inputs must leave the registered state alone.
    drive(1'b0, 4'b1111, 4'b0110, 1'b0);
    drive(1'b1, 4'b0011, 4'b0011, 1'b0);
    drive(1'b0, 4'b0101, 4'b1001, 1'b0);

    // Build up to M=0001, sel_changes=3, then reset mid-cycle.
    drive(1'b0, 4'b0000, 4'b0001, 1'b1);
    drive(1'b1, 4'b0000, 4'b0001, 1'b1);
    chk("pre_reset_cnt", sel_changes, 3);
    chk("pre_reset_m", M, 1);
    pulse_reset();
    // The first capture after release must not count, even though SE=1
    // differs from the reset value of last_se.
    drive(1'b1, 4'b0010, 4'b0100, 1'b1);
    chk("post_reset_cnt", sel_changes, 0);
    drive(1'b1, 4'b0010, 4'b0100, 1'b1);
    drive(1'b0, 4'b0010, 4'b0100, 1'b1);

    // Saturation: equal data, SE toggling, 300 valid cycles.
    pulse_reset();
    for (int i = 0; i < 300; i++) drive(i[0], 4'b1010, 4'b1010, 1'b1);
    chk("sat_cnt", sel_changes, 255);
    chk("sat_m", M, 4'b1010);
    chk("sat_eq", eq, 1);

    // Exhaustive mux check, with an occasional idle cycle mixed in.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          drive(s[0], x[WIDTH-1:0], y[WIDTH-1:0], ($urandom_range(0, 7) != 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/part2.md
PART2 -- requirements
Module: part2

Interface
REQ-001 Parameter WIDTH, default 4: data width of both mux inputs and of the output.
REQ-002 Parameter CNT_W, default 8: width of the select-change counter.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port SE  input  1  mux select line (0 selects XIN, 1 selects YIN).
REQ-006 Port XIN  input  WIDTH  data input 0.
REQ-007 Port YIN  input  WIDTH  data input 1.
REQ-008 Port in_valid  input  1  qualifies SE/XIN/YIN for capture this cycle.
REQ-009 Port M_comb  output  WIDTH  combinational mux result.
REQ-010 Port M  output  WIDTH  registered mux result.
REQ-011 Port out_valid  output  1  M holds a result captured from a valid input.
REQ-012 Port eq  output  1  registered flag: XIN equalled YIN at the last capture.
REQ-013 Port sel_changes  output  CNT_W  saturating count of captured select toggles.
REQ-014 One clock, clk; reset is asynchronous and active-high, port reset; no other clocks or resets.

Function
REQ-015 M_comb SHALL equal XIN when SE=0 and YIN when SE=1, every bit, with no clock dependency.
REQ-016 SE of X/Z SHALL NOT be required to resolve; synthesis behaviour only is specified.
REQ-017 On a rising clk with in_valid=1, M SHALL load M_comb; latency from input to M exactly 1 cycle.
REQ-018 On a rising clk with in_valid=1, eq SHALL load (XIN==YIN).
REQ-019 On a rising clk with in_valid=0, M and eq SHALL hold their previous values.
REQ-020 out_valid SHALL be a 1-cycle-delayed copy of in_valid (set when a capture occurred last edge, cleared otherwise).
REQ-021 An internal register last_se SHALL hold the SE value of the most recent capture; it updates only when in_valid=1.
REQ-022 A capture SHALL count as a select change when in_valid=1, a prior capture exists since reset, and SE differs from last_se.
REQ-023 The first capture after reset SHALL never count as a change (it only primes last_se).
REQ-024 sel_changes SHALL increment by 1 per counted change and saturate at 2^CNT_W-1 (no wrap-around).
REQ-025 Inputs changing while in_valid=0 SHALL affect only M_comb, never registered state.
REQ-026 Each output bit of M is independent; no arithmetic, no sign extension, widths fixed at WIDTH.

Reset
REQ-027 While reset=1, regardless of clk: M=0, eq=0, out_valid=0, sel_changes=0, last_se=0, primed flag cleared.
REQ-028 Reset assertion SHALL take effect immediately (asynchronous); deassertion is sampled on the next rising clk.
REQ-029 Reset asserted mid-stream SHALL discard any capture in that cycle; M_comb remains purely combinational during reset.
REQ-030 First capture SHALL occur on the first rising clk after reset deasserts with in_valid=1.

Verification
REQ-031 XIN=0000, YIN=0001, SE=0, in_valid=1 -> M_comb=0000 immediately; M=0000, out_valid=1, eq=0 after 1 clk.
REQ-032 Then SE=1 (same data) -> M_comb=0001 immediately; M=0001 after next clk; sel_changes=1.
REQ-033 XIN=YIN=1010, SE toggled every cycle for 300 valid cycles, CNT_W=8 -> M=1010, eq=1, sel_changes saturates at 255.
REQ-034 in_valid=0 while XIN/YIN/SE change -> M, eq, sel_changes unchanged; out_valid=0 one cycle later.
REQ-035 reset pulsed between clk edges with M=0001, sel_changes=3 -> all registered outputs 0 at once; first capture after release does not count a change.
REQ-036 Exhaustive: all 16x16 XIN/YIN pairs x both SE values -> M_comb and (1 cycle later) M match select rule of REQ-015.
